// File: rtl/orientation_stream_unit_if.sv
// Column stream into, and orientation results out of, the ORB orientation unit.
// The feeder side uses master; the orientation unit uses slave.
interface orientation_stream_unit_if #(
    parameter int RADIUS   = 3,
    parameter int PIX_W    = 8,
    parameter int OUT_FRAC = 10
);
    localparam int N     = 2 * RADIUS + 1;
    localparam int MOM_W = PIX_W + $clog2(N * RADIUS * (RADIUS + 1) / 2 + 1) + 1;

    logic [N*PIX_W-1:0]        i_col;
    logic                      i_valid;
    logic                      i_sol;
    logic                      o_valid;
    logic signed [OUT_FRAC+1:0] o_cos;
    logic signed [OUT_FRAC+1:0] o_sin;
    logic signed [MOM_W-1:0]    o_mx;
    logic signed [MOM_W-1:0]    o_my;

    modport master (
        output i_col, i_valid, i_sol,
        input  o_valid, o_cos, o_sin, o_mx, o_my
    );

    modport slave (
        input  i_col, i_valid, i_sol,
        output o_valid, o_cos, o_sin, o_mx, o_my
    );
endinterface

// File: rtl/orientation_stream_unit.sv
// Intensity-centroid orientation over a sliding N x N patch fed one column per beat.
// A systolic chain builds m10/m01; a free-running 5-stage pipeline normalises to cos/sin.
module orientation_stream_unit #(
    parameter int RADIUS   = 3,
    parameter int PIX_W    = 8,
    parameter int OUT_FRAC = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    orientation_stream_unit_if.slave bus
);
    localparam int N      = 2 * RADIUS + 1;
    localparam int MOM_W  = PIX_W + $clog2(N * RADIUS * (RADIUS + 1) / 2 + 1) + 1;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int SQ_W   = 2 * MOM_W;
    localparam int SUM_W  = 2 * MOM_W + 1;
    localparam int ROOT_W = MOM_W + 1;
    localparam int QW     = MOM_W + OUT_FRAC;
    localparam int OUT_W  = OUT_FRAC + 2;
    localparam int WB     = $clog2(RADIUS + 1) + 1;
    localparam logic [OUT_FRAC:0] Q_ONE = {1'b1, {OUT_FRAC{1'b0}}};

    typedef logic signed [MOM_W-1:0] mom_t;

    // Fields that ride alongside the arithmetic through every normalisation stage.
    typedef struct packed {
        logic v;
        mom_t mx;
        mom_t my;
    } meta_t;

    // Multiply by a small elaboration-time constant using shifts and adds only.
    function automatic mom_t scale(input mom_t v, input int w);
        mom_t acc;
        int   mag;
        acc = '0;
        mag = (w < 0) ? -w : w;
        for (int b = 0; b < WB; b++) begin
            if (mag[b]) acc = acc + (v <<< b);
        end
        return (w < 0) ? -acc : acc;
    endfunction

    function automatic logic [MOM_W-1:0] abs_mom(input mom_t v);
        return v[MOM_W-1] ? MOM_W'(-v) : MOM_W'(v);
    endfunction

    // Digit-by-digit floor square root.
    function automatic logic [ROOT_W-1:0] isqrt(input logic [SUM_W-1:0] v);
        logic [SUM_W-1:0] rem;
        logic [SUM_W-1:0] res;
        logic [SUM_W-1:0] one;
        rem = v;
        res = '0;
        one = SUM_W'(1) << (2 * (ROOT_W - 1));
        for (int i = 0; i < ROOT_W; i++) begin
            if (rem >= res + one) begin
                rem = rem - (res + one);
                res = (res >> 1) + one;
            end else begin
                res = res >> 1;
            end
            one = one >> 2;
        end
        return ROOT_W'(res);
    endfunction

    // ---------------- column sums and window tracking ----------------
    mom_t             col_s;
    mom_t             col_y;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        mom_t pix;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        col_s = '0;
        col_y = '0;
        pix   = '0;
        for (int r = 0; r < N; r++) begin
            pix   = mom_t'({{(MOM_W - PIX_W){1'b0}}, bus.i_col[r*PIX_W +: PIX_W]});
            col_s = col_s + pix;
            col_y = col_y + scale(pix, r - RADIUS);
        end
    end

    always_comb begin
        cnt_next = cnt_q;
        if (bus.i_valid) begin
            if (bus.i_sol) cnt_next = CNT_W'(1);
            else if (cnt_q != CNT_W'(N)) cnt_next = cnt_q + 1'b1;
        end
    end

    // Stage k weights the incoming column by x = k - RADIUS, so the last stage sees the newest at +RADIUS.
    mom_t px_q [N];
    mom_t py_q [N];
    logic tag_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: these partial sums are plain flops, not a RAM, so they are reset like any other state.
            for (int k = 0; k < N; k++) begin
                px_q[k] <= '0;
                py_q[k] <= '0;
            end
            cnt_q <= '0;
            tag_q <= 1'b0;
        end else begin
            tag_q <= bus.i_valid && (cnt_next == CNT_W'(N));
            if (bus.i_valid) begin
                cnt_q   <= cnt_next;
                px_q[0] <= scale(col_s, -RADIUS);
                py_q[0] <= col_y;
                for (int k = 1; k < N; k++) begin
                    px_q[k] <= px_q[k-1] + scale(col_s, k - RADIUS);
                    py_q[k] <= py_q[k-1] + col_y;
                end
            end
        end
    end

    // ---------------- normalisation pipeline ----------------
    meta_t              s1, s2, s3, s4, s5;
    logic [MOM_W-1:0]   s1_ax, s1_ay, s2_ax, s2_ay, s3_ax, s3_ay, s4_ax, s4_ay;
    logic [SQ_W-1:0]    s2_sqx, s2_sqy;
    logic [SUM_W-1:0]   s3_sum;
    logic [ROOT_W-1:0]  s4_root;
    logic               s4_zero;
    logic [OUT_FRAC:0]  s5_qx, s5_qy;
    logic [ROOT_W-1:0]  root_c;
    logic [QW-1:0]      quo_x, quo_y;
    logic [OUT_FRAC:0]  q_x, q_y;

    assign root_c = isqrt(s3_sum);

    always_comb begin
        quo_x = {s4_ax, {OUT_FRAC{1'b0}}} / QW'(s4_root);
        quo_y = {s4_ay, {OUT_FRAC{1'b0}}} / QW'(s4_root);
        q_x   = (quo_x > QW'(Q_ONE)) ? Q_ONE : quo_x[OUT_FRAC:0];
        q_y   = (quo_y > QW'(Q_ONE)) ? Q_ONE : quo_y[OUT_FRAC:0];
        // A zero moment vector has no direction; report angle 0.
        if (s4_zero) begin
            q_x = Q_ONE;
            q_y = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1 <= '0; s2 <= '0; s3 <= '0; s4 <= '0; s5 <= '0;
            s1_ax <= '0; s1_ay <= '0; s2_ax <= '0; s2_ay <= '0;
            s3_ax <= '0; s3_ay <= '0; s4_ax <= '0; s4_ay <= '0;
            s2_sqx <= '0; s2_sqy <= '0; s3_sum <= '0;
            s4_root <= '0; s4_zero <= 1'b0;
            s5_qx <= '0; s5_qy <= '0;
        end else begin
            s1    <= '{v: tag_q, mx: px_q[N-1], my: py_q[N-1]};
            s1_ax <= abs_mom(px_q[N-1]);
            s1_ay <= abs_mom(py_q[N-1]);

            s2     <= s1;
            s2_ax  <= s1_ax;
            s2_ay  <= s1_ay;
            s2_sqx <= {{MOM_W{1'b0}}, s1_ax} * {{MOM_W{1'b0}}, s1_ax};
            s2_sqy <= {{MOM_W{1'b0}}, s1_ay} * {{MOM_W{1'b0}}, s1_ay};

            s3     <= s2;
            s3_ax  <= s2_ax;
            s3_ay  <= s2_ay;
            s3_sum <= SUM_W'(s2_sqx) + SUM_W'(s2_sqy);

            s4      <= s3;
            s4_ax   <= s3_ax;
            s4_ay   <= s3_ay;
            s4_zero <= (s3_sum == '0);
            s4_root <= (root_c == '0) ? ROOT_W'(1) : root_c;

            s5    <= s4;
            s5_qx <= q_x;
            s5_qy <= q_y;
        end
    end

    // ---------------- output register ----------------
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_cos, out_sin;
    mom_t                    out_mx, out_my;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid <= 1'b0;
            out_cos   <= '0;
            out_sin   <= '0;
            out_mx    <= '0;
            out_my    <= '0;
        end else begin
            out_valid <= s5.v;
            if (s5.v) begin
                out_cos <= s5.mx[MOM_W-1] ? -OUT_W'(s5_qx) : OUT_W'(s5_qx);
                out_sin <= s5.my[MOM_W-1] ? -OUT_W'(s5_qy) : OUT_W'(s5_qy);
                out_mx  <= s5.mx;
                out_my  <= s5.my;
            end
        end
    end

    assign bus.o_valid = out_valid;
    assign bus.o_cos   = out_cos;
    assign bus.o_sin   = out_sin;
    assign bus.o_mx    = out_mx;
    assign bus.o_my    = out_my;
endmodule

// File: tb/tb_orientation_stream_unit.sv
// Directed and random column streams against a window-queue reference model of the orientation unit.
module tb_orientation_stream_unit;
    localparam int RADIUS   = 3;
    localparam int PIX_W    = 8;
    localparam int OUT_FRAC = 10;
    localparam int N        = 2 * RADIUS + 1;
    localparam int MOM_W    = PIX_W + $clog2(N * RADIUS * (RADIUS + 1) / 2 + 1) + 1;
    localparam int OUT_W    = OUT_FRAC + 2;
    localparam int LAT      = 6;

    typedef logic [N*PIX_W-1:0] col_t;

    typedef struct packed {
        int                      due;
        logic signed [MOM_W-1:0] mx;
        logic signed [MOM_W-1:0] my;
        logic signed [OUT_W-1:0] c;
        logic signed [OUT_W-1:0] s;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    orientation_stream_unit_if #(.RADIUS(RADIUS), .PIX_W(PIX_W), .OUT_FRAC(OUT_FRAC)) bus ();

    orientation_stream_unit #(.RADIUS(RADIUS), .PIX_W(PIX_W), .OUT_FRAC(OUT_FRAC)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    col_t win [$];
    exp_t exp_q [$];
    exp_t last;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint isqrt_ref(input longint s);
        longint r;
        r = longint'($sqrt(real'(s)));
        while (r * r > s) r--;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    // Centroid of the current window: x is column age (oldest -RADIUS), y is row - RADIUS.
    function automatic exp_t window_result(input int due);
        exp_t   e;
        col_t   col;
        int     m10, m01, ax, ay, qx, qy, p;
        longint ss, root;
        m10 = 0;
        m01 = 0;
        for (int c = 0; c < N; c++) begin
            col = win[c];
            for (int r = 0; r < N; r++) begin
                p   = int'(col[r*PIX_W +: PIX_W]);
                m10 += (c - RADIUS) * p;
                m01 += (r - RADIUS) * p;
            end
        end
        ax = (m10 < 0) ? -m10 : m10;
        ay = (m01 < 0) ? -m01 : m01;
        ss = longint'(ax) * ax + longint'(ay) * ay;
        if (ss == 0) begin
            qx = 1 << OUT_FRAC;
            qy = 0;
        end else begin
            root = isqrt_ref(ss);
            qx = int'((longint'(ax) << OUT_FRAC) / root);
            qy = int'((longint'(ay) << OUT_FRAC) / root);
            if (qx > (1 << OUT_FRAC)) qx = 1 << OUT_FRAC;
            if (qy > (1 << OUT_FRAC)) qy = 1 << OUT_FRAC;
        end
        e.due = due;
        e.mx  = MOM_W'(m10);
        e.my  = MOM_W'(m01);
        e.c   = OUT_W'((m10 < 0) ? -qx : qx);
        e.s   = OUT_W'((m01 < 0) ? -qy : qy);
        return e;
    endfunction

    task automatic model_edge();
        cyc++;
        if (rst_n && bus.i_valid) begin
            if (bus.i_sol) win.delete();
            win.push_back(bus.i_col);
            if (win.size() > N) void'(win.pop_front());
            if (win.size() == N) exp_q.push_back(window_result(cyc + LAT));
        end
    endtask

    task automatic check_outputs();
        logic exp_v;
        exp_v = 1'b0;
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            exp_v = 1'b1;
            last  = exp_q.pop_front();
        end
        check("o_valid", bus.o_valid, exp_v);
        check("o_mx", bus.o_mx, $signed(last.mx));
        check("o_my", bus.o_my, $signed(last.my));
        check("o_cos", bus.o_cos, $signed(last.c));
        check("o_sin", bus.o_sin, $signed(last.s));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        bus.i_valid = 1'b0;
        bus.i_sol   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic sol, input col_t col);
        bus.i_valid = 1'b1;
        bus.i_sol   = sol;
        bus.i_col   = col;
        tick();
        bus.i_valid = 1'b0;
        bus.i_sol   = 1'b0;
    endtask

    function automatic col_t fill(input int v);
        col_t c;
        for (int r = 0; r < N; r++) c[r*PIX_W +: PIX_W] = PIX_W'(v);
        return c;
    endfunction

    function automatic col_t one_row(input int row, input int v);
        col_t c;
        c = '0;
        c[row*PIX_W +: PIX_W] = PIX_W'(v);
        return c;
    endfunction

    function automatic col_t rand_col();
        col_t c;
        for (int r = 0; r < N; r++) begin
            case ($urandom_range(0, 5))
                0:       c[r*PIX_W +: PIX_W] = '0;
                1:       c[r*PIX_W +: PIX_W] = '1;
                default: c[r*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
            endcase
        end
        return c;
    endfunction

    initial begin
        last        = '0;
        bus.i_valid = 1'b0;
        bus.i_sol   = 1'b0;
        bus.i_col   = '0;

        // Reset state.
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Uniform patch.
        send(1'b1, fill(100));
        repeat (N - 1) send(1'b0, fill(100));
        idle(8);
        check("uni_mx", bus.o_mx, 0);
        check("uni_my", bus.o_my, 0);
        check("uni_cos", bus.o_cos, 1024);
        check("uni_sin", bus.o_sin, 0);

        // Newest column bright.
        send(1'b1, fill(0));
        repeat (N - 2) send(1'b0, fill(0));
        send(1'b0, fill(255));
        idle(8);
        check("newest_mx", bus.o_mx, 5355);
        check("newest_my", bus.o_my, 0);
        check("newest_cos", bus.o_cos, 1024);
        check("newest_sin", bus.o_sin, 0);

        // Bottom row bright.
        send(1'b1, one_row(N - 1, 255));
        repeat (N - 1) send(1'b0, one_row(N - 1, 255));
        idle(8);
        check("bottom_mx", bus.o_mx, 0);
        check("bottom_my", bus.o_my, 5355);
        check("bottom_cos", bus.o_cos, 0);
        check("bottom_sin", bus.o_sin, 1024);

        // Single pixel at oldest column, top row.
        send(1'b1, one_row(0, 200));
        repeat (N - 1) send(1'b0, fill(0));
        idle(8);
        check("corner_mx", bus.o_mx, -600);
        check("corner_my", bus.o_my, -600);
        check("corner_cos", bus.o_cos, -724);
        check("corner_sin", bus.o_sin, -724);

        // Input gap before the completing column, then a back-to-back column.
        send(1'b1, rand_col());
        repeat (N - 2) send(1'b0, rand_col());
        idle(10);
        send(1'b0, rand_col());
        send(1'b0, rand_col());
        idle(8);

        // Mid-line restart.
        send(1'b1, rand_col());
        repeat (3) send(1'b0, rand_col());
        send(1'b1, rand_col());
        repeat (N - 2) send(1'b0, rand_col());
        idle(3);
        send(1'b0, rand_col());
        idle(8);

        // Random stream with gaps and occasional line starts.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 75) send($urandom_range(0, 99) < 4, rand_col());
            else idle(1);
        end
        idle(8);

        // Asynchronous reset with three windows in flight.
        send(1'b1, rand_col());
        repeat (N) send(1'b0, rand_col());
        bus.i_valid = 1'b1;
        bus.i_sol   = 1'b0;
        bus.i_col   = rand_col();
        @(posedge clk);
        model_edge();
        #2;
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        check("rst_valid", bus.o_valid, 0);
        check("rst_mx", bus.o_mx, 0);
        check("rst_my", bus.o_my, 0);
        check("rst_cos", bus.o_cos, 0);
        check("rst_sin", bus.o_sin, 0);
        win.delete();
        exp_q.delete();
        last = '0;
        @(negedge clk);
        check_outputs();
        idle(2);
        rst_n = 1'b1;
        idle(LAT + 2);
        send(1'b1, rand_col());
        repeat (N - 2) send(1'b0, rand_col());
        idle(4);
        send(1'b0, rand_col());
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
